// File: rtl/track_recorder.sv
// track_recorder: packs per-tick key presses into 16-bit track RAM words.
// One nibble per track, bit k = tick k of the word (bit 0 plays first).
//
// Ports:
//   CLOCK_50   system clock, rising edge
//   reset_n    synchronous active-low reset
//   tick       single-cycle game-tick pulse
//   start      pulse, begins a session (from IDLE or DONE)
//   stop       pulse, ends the session early
//   key_n[3:0] raw active-low keys, [3]->track1 ... [0]->track4
//   wr_en      one-cycle RAM write strobe
//   wr_addr    RAM address of the current write
//   wr_data    {track1, track2, track3, track4} nibbles
//   busy       high in ARM, RECORD and FLUSH
//   done       high in DONE
//   word_count words written this session
//
// Build option: define TRACK_RECORDER_EDGE_EN to capture press edges
// only; otherwise any cycle a key is down sets the track bit.
module track_recorder #(
  parameter int ADDR_W         = 7,
  parameter int DEPTH          = 128,
  parameter int TICKS_PER_WORD = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        key_n,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REC,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        s1_q, s2_q;
  logic [3:0]        latch_q, latch_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   pack_q, pack_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic [3:0]        p;
  logic [3:0]        hit;
  logic [3:0]        bits;
  logic              last_addr;

  assign p = ~s2_q;

`ifdef TRACK_RECORDER_EDGE_EN
  logic [3:0] pprev_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      pprev_q <= '0;
    end else begin
      pprev_q <= p;
    end
  end

  assign hit = p & ~pprev_q;
`else
  assign hit = p;
`endif

  // Current-cycle press is folded in so the tick cycle itself counts.
  assign bits      = latch_q | hit;
  assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    cnt_d   = cnt_q;

    // Retire the write issued last cycle; the address holds at the end.
    if (wr_q) begin
      pack_d = '0;
      cnt_d  = cnt_q + 1'b1;
      if (!last_addr) begin
        addr_d = addr_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ARM;
          addr_d  = '0;
          cnt_d   = '0;
          latch_d = '0;
        end
      end
      S_ARM: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (tick) begin
          state_d = S_REC;
          idx_d   = '0;
          latch_d = '0;
          pack_d  = '0;
        end
      end
      S_REC: begin
        latch_d = bits;
        if (tick) begin
          for (int i = 0; i < 4; i++) begin
            pack_d[i][idx_q] = bits[i];
          end
          latch_d = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 2'(TICKS_PER_WORD - 1)) begin
            wr_d = 1'b1;
          end
        end
        // Stop sees the index after any same-cycle tick.
        if (stop) begin
          if (idx_d != '0) begin
            state_d = S_FLUSH;
            wr_d    = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Last address written: the track is full.
    if (wr_q && last_addr &&
        (state_q == S_REC || state_q == S_FLUSH)) begin
      state_d = S_DONE;
      wr_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      s1_q    <= '1;
      s2_q    <= '1;
      latch_q <= '0;
      idx_q   <= '0;
      pack_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= key_n;
      s2_q    <= s1_q;
      latch_q <= latch_d;
      idx_q   <= idx_d;
      pack_q  <= pack_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_en      = wr_q;
  assign wr_addr    = addr_q;
  assign wr_data    = wr_q ? pack_q : 16'h0000;
  assign busy       = (state_q == S_ARM) || (state_q == S_REC) ||
                      (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);
  assign word_count = cnt_q;

endmodule

// File: tb/tb_track_recorder.sv
// tb_track_recorder: randomized and directed stimulus for track_recorder,
// checked every cycle against a window/queue based reference model.
module tb_track_recorder;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
`ifdef TRACK_RECORDER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ARM   = 1;
  localparam int M_REC   = 2;
  localparam int M_FLUSH = 3;
  localparam int M_DONE  = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick  = 1'b0;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic [3:0]        key_n = 4'hF;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;

  track_recorder #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .TICKS_PER_WORD(4)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(rst_n),
    .tick(tick),
    .start(start),
    .stop(stop),
    .key_n(key_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  int        m_mode = M_IDLE;
  int        m_cnt  = 0;
  int        m_idx  = 0;
  bit        m_wr   = 1'b0;
  bit [15:0] m_word = 16'h0;
  bit [15:0] m_acc  = 16'h0;
  bit [3:0]  kd0    = 4'hF;
  bit [3:0]  kd1    = 4'hF;
  bit [3:0]  m_pp   = 4'h0;
  bit [3:0]  win_q[$];

  logic [ADDR_W-1:0] la[$];
  logic [15:0]       ld[$];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic model_edge();
    bit [3:0] p;
    bit [3:0] ev;
    bit [3:0] bits;
    bit       was_wr;
    int       oldm;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_wr   = 1'b0;
      m_cnt  = 0;
      m_idx  = 0;
      m_acc  = 16'h0;
      m_word = 16'h0;
      kd0    = 4'hF;
      kd1    = 4'hF;
      m_pp   = 4'h0;
      win_q.delete();
      return;
    end
    p    = ~kd1;
    kd1  = kd0;
    kd0  = key_n;
    ev   = EDGE ? (p & ~m_pp) : p;
    m_pp = p;
    was_wr = m_wr;
    m_wr   = 1'b0;
    oldm   = m_mode;
    if (was_wr) m_cnt++;
    case (oldm)
      M_IDLE, M_DONE: begin
        if (start) begin
          m_mode = M_ARM;
          m_cnt  = 0;
        end
      end
      M_ARM: begin
        if (stop) m_mode = M_DONE;
        else if (tick) begin
          m_mode = M_REC;
          m_idx  = 0;
          m_acc  = 16'h0;
          win_q.delete();
        end
      end
      M_REC: begin
        win_q.push_back(ev);
        if (tick) begin
          bits = 4'h0;
          foreach (win_q[j]) bits |= win_q[j];
          win_q.delete();
          for (int i = 0; i < 4; i++) m_acc[i*4 + m_idx] = bits[i];
          m_idx = (m_idx + 1) % 4;
          if (m_idx == 0) begin
            m_word = m_acc;
            m_acc  = 16'h0;
            m_wr   = 1'b1;
          end
        end
        if (stop) begin
          if (m_idx != 0) begin
            m_mode = M_FLUSH;
            m_word = m_acc;
            m_acc  = 16'h0;
            m_wr   = 1'b1;
          end else begin
            m_mode = M_DONE;
          end
        end
      end
      M_FLUSH: m_mode = M_DONE;
      default: ;
    endcase
    if (was_wr && m_cnt == DEPTH &&
        (oldm == M_REC || oldm == M_FLUSH)) begin
      m_mode = M_DONE;
      m_wr   = 1'b0;
    end
  endtask

  task automatic cyc();
    logic [ADDR_W-1:0] ea;
    logic              eb;
    logic              ed;
    @(posedge clk);
    model_edge();
    #1;
    ea = (m_cnt >= DEPTH) ? ADDR_W'(DEPTH - 1) : ADDR_W'(m_cnt);
    eb = (m_mode == M_ARM) || (m_mode == M_REC) || (m_mode == M_FLUSH);
    ed = (m_mode == M_DONE);
    chk("cycle",
        64'({wr_en, wr_addr, wr_data, busy, done, word_count}),
        64'({m_wr, ea, (m_wr ? m_word : 16'h0), eb, ed,
             (ADDR_W+1)'(m_cnt)}));
    if (wr_en === 1'b1) begin
      la.push_back(wr_addr);
      ld.push_back(wr_data);
    end
  endtask

  task automatic step(bit t, bit st, bit sp);
    tick  = t;
    start = st;
    stop  = sp;
    cyc();
    tick  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tk(int n, int gap);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0);
      idle(gap - 1);
    end
  endtask

  task automatic clr_log();
    la.delete();
    ld.delete();
  endtask

  task automatic arm();
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int bad;
    int since;
    bit t;
    bit st;
    bit sp;

    idle(3);
    chk("reset_state",
        64'({wr_en, wr_addr, wr_data, busy, done, word_count}), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // One key[3] press inside the second window only.
    clr_log();
    arm();
    idle(7);
    step(1'b1, 1'b0, 1'b0);
    key_n[3] = 1'b0;
    idle(4);
    key_n[3] = 1'b1;
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    chk("one_word_nwr", 64'(la.size()), 64'(1));
    chk("one_word_addr", 64'(la[0]), 64'(0));
    chk("one_word_data", 64'(ld[0]), 64'(16'h2000));
    chk("one_word_cnt", 64'(word_count), 64'(1));
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    chk("stop_idx0_done", 64'(done), 64'(1));
    chk("stop_idx0_nwr", 64'(la.size()), 64'(1));

    // key[0] held across eight ticks.
    clr_log();
    arm();
    idle(1);
    key_n[0] = 1'b0;
    idle(4);
    tk(8, 6);
    key_n[0] = 1'b1;
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    chk("hold_nwr", 64'(la.size()), 64'(2));
    chk("hold_addr1", 64'(la[1]), 64'(1));
`ifdef TRACK_RECORDER_EDGE_EN
    chk("hold_w0", 64'(ld[0]), 64'(16'h0001));
    chk("hold_w1", 64'(ld[1]), 64'(16'h0000));
`else
    chk("hold_w0", 64'(ld[0]), 64'(16'h000F));
    chk("hold_w1", 64'(ld[1]), 64'(16'h000F));
`endif

    // Two windows with key[2], then stop -> partial word.
    clr_log();
    arm();
    idle(1);
    key_n[2] = 1'b0;
    idle(2);
    key_n[2] = 1'b1;
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    key_n[2] = 1'b0;
    idle(2);
    key_n[2] = 1'b1;
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    chk("flush_nwr", 64'(la.size()), 64'(1));
    chk("flush_addr", 64'(la[0]), 64'(0));
    chk("flush_data", 64'(ld[0]), 64'(16'h0300));
    chk("flush_done", 64'(done), 64'(1));
    chk("flush_cnt", 64'(word_count), 64'(1));

    // Stop on the tick that completes a word.
    clr_log();
    arm();
    idle(3);
    tk(3, 4);
    step(1'b1, 1'b0, 1'b1);
    idle(3);
    chk("tickstop_nwr", 64'(la.size()), 64'(1));
    chk("tickstop_done", 64'(done), 64'(1));
    chk("tickstop_cnt", 64'(word_count), 64'(1));

    // Reset in the middle of a word.
    arm();
    idle(3);
    tk(2, 4);
    clr_log();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_mid",
        64'({wr_en, wr_addr, wr_data, busy, done, word_count}), 64'(0));
    rst_n = 1'b1;
    tk(6, 4);
    chk("rst_mid_nwr", 64'(la.size()), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));

    // Fill the whole track.
    clr_log();
    arm();
    idle(2);
    for (int n = 0; n < 512; n++) begin
      key_n = 4'($urandom);
      step(1'b1, 1'b0, 1'b0);
      key_n = 4'($urandom);
      idle(2);
    end
    key_n = 4'hF;
    idle(2);
    chk("full_nwr", 64'(la.size()), 64'(DEPTH));
    bad = 0;
    foreach (la[j]) if (la[j] !== ADDR_W'(j)) bad++;
    chk("full_addr_seq", 64'(bad), 64'(0));
    chk("full_cnt", 64'(word_count), 64'(DEPTH));
    chk("full_done", 64'(done), 64'(1));
    chk("full_last_addr", 64'(wr_addr), 64'(DEPTH - 1));
    clr_log();
    tk(8, 3);
    chk("full_no_more", 64'(la.size()), 64'(0));

    // Random traffic with the tick spacing respected.
    since = 10;
    for (int c = 0; c < 5000; c++) begin
      t  = (since >= 3) && ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 49) == 0);
      sp = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 3) == 0) key_n = 4'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      since = t ? 1 : since + 1;
      step(t, st, sp);
    end
    rst_n = 1'b1;
    idle(4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
